// File: rtl/fifo_seq_checker_if.sv
// Read-side handshake between a first-word-fall-through FIFO and its consumer.
// The master (the checker) drives r_en; the slave (the FIFO) drives rrdy and rdata.
interface fifo_seq_checker_if #(
  parameter int DWIDTH = 8
);
  logic              r_en;
  logic              rrdy;
  logic [DWIDTH-1:0] rdata;

  modport master (output r_en, input rrdy, input rdata);
  modport slave  (input r_en, output rrdy, output rdata);
endinterface

// File: rtl/fifo_seq_checker.sv
// Reads a programmed number of words from the FIFO read port and checks them against an
// incrementing sequence. Optional read throttling by an LFSR: define SEQCHK_THROTTLE_EN.
module fifo_seq_checker #(
  parameter int DWIDTH    = 8,
  parameter int CNTW      = 16,
  parameter int START_VAL = 1,
  parameter int TOUT      = 1024
) (
  input  logic                 rclk,
  input  logic                 r_rstn,
  input  logic                 start,
  input  logic [CNTW-1:0]      num_words,
  fifo_seq_checker_if.master   rd_if,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [CNTW-1:0]      rd_cnt,
  output logic [CNTW-1:0]      err_cnt,
  output logic [DWIDTH-1:0]    exp_data
);

  localparam int                IW       = (TOUT > 1) ? $clog2(TOUT) : 1;
  localparam logic [IW-1:0]     IDLE_MAX = IW'(TOUT - 1);
  localparam logic [DWIDTH-1:0] START_D  = DWIDTH'(START_VAL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                r_en_q, r_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic [CNTW-1:0]     remaining_q, remaining_d;
  logic [CNTW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [CNTW-1:0]     err_cnt_q, err_cnt_d;
  logic [IW-1:0]       idle_q, idle_d;
  logic [DWIDTH-1:0]   exp_q, exp_d;
  logic                fire;
  logic                idle_tick;
  logic                start_ok;

`ifdef SEQCHK_THROTTLE_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr_q, lfsr_d;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    remaining_d = remaining_q;
    rd_cnt_d    = rd_cnt_q;
    err_cnt_d   = err_cnt_q;
    idle_d      = idle_q;
    exp_d       = exp_q;

    fire     = r_en_q && rd_if.rrdy;
    start_ok = start && (state_q != S_RUN);
`ifdef SEQCHK_THROTTLE_EN
    // Throttled cycles are our own choice, not the FIFO's fault: only stalls while requesting count.
    idle_tick = r_en_q && !rd_if.rrdy;
`else
    idle_tick = !rd_if.rrdy;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          remaining_d = num_words;
          rd_cnt_d    = '0;
          err_cnt_d   = '0;
          timeout_d   = 1'b0;
          idle_d      = '0;
          exp_d       = START_D;
          if (num_words == '0) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            pass_d  = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (fire) begin
          rd_cnt_d    = rd_cnt_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          idle_d      = '0;
          // Resync on the received word so a single dropped word costs one error, not a run of them.
          exp_d       = rd_if.rdata + 1'b1;
          if (rd_if.rdata != exp_q && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          if (remaining_q == CNTW'(1)) begin
            state_d = S_DONE;
            pass_d  = (err_cnt_d == '0);
          end
        end else if (idle_tick) begin
          if (idle_q == IDLE_MAX) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
            pass_d    = 1'b0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SEQCHK_THROTTLE_EN
    lfsr_d = lfsr_q;
    if (start_ok) begin
      lfsr_d = LFSR_SEED;
    end else if (state_q == S_RUN) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    r_en_d = (state_d == S_RUN) && lfsr_d[0];
`else
    r_en_d = (state_d == S_RUN);
`endif
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge rclk or negedge r_rstn) begin
    if (!r_rstn) begin
      state_q     <= S_IDLE;
      r_en_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      remaining_q <= '0;
      rd_cnt_q    <= '0;
      err_cnt_q   <= '0;
      idle_q      <= '0;
      exp_q       <= START_D;
`ifdef SEQCHK_THROTTLE_EN
      lfsr_q      <= LFSR_SEED;
`endif
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      r_en_q      <= r_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      remaining_q <= remaining_d;
      rd_cnt_q    <= rd_cnt_d;
      err_cnt_q   <= err_cnt_d;
      idle_q      <= idle_d;
      exp_q       <= exp_d;
`ifdef SEQCHK_THROTTLE_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  assign rd_if.r_en = r_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign rd_cnt     = rd_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign exp_data   = exp_q;

endmodule

// File: tb/tb_fifo_seq_checker.sv
// Self-checking bench: two checkers (START_VAL 1 and 250, TOUT 16) each fed by a queue-modelled FIFO.
// Table-driven directed runs, hand sequences for reset/start corner cases, then random runs vs a model.
module tb_fifo_seq_checker;

  localparam int DW   = 8;
  localparam int CW   = 16;
  localparam int TOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start [2];
  logic [CW-1:0] nw    [2];
  logic          o_busy[2], o_done[2], o_pass[2], o_tmo[2];
  logic [CW-1:0] o_rd  [2], o_err[2];
  logic [DW-1:0] o_exp [2];

  fifo_seq_checker_if #(.DWIDTH(DW)) if_a ();
  fifo_seq_checker_if #(.DWIDTH(DW)) if_b ();

  fifo_seq_checker #(.DWIDTH(DW), .CNTW(CW), .START_VAL(1), .TOUT(TOUT)) dut_a (
    .rclk(clk), .r_rstn(rst_n), .start(start[0]), .num_words(nw[0]), .rd_if(if_a),
    .busy(o_busy[0]), .done(o_done[0]), .pass(o_pass[0]), .timeout(o_tmo[0]),
    .rd_cnt(o_rd[0]), .err_cnt(o_err[0]), .exp_data(o_exp[0])
  );

  fifo_seq_checker #(.DWIDTH(DW), .CNTW(CW), .START_VAL(250), .TOUT(TOUT)) dut_b (
    .rclk(clk), .r_rstn(rst_n), .start(start[1]), .num_words(nw[1]), .rd_if(if_b),
    .busy(o_busy[1]), .done(o_done[1]), .pass(o_pass[1]), .timeout(o_tmo[1]),
    .rd_cnt(o_rd[1]), .err_cnt(o_err[1]), .exp_data(o_exp[1])
  );

  logic [DW-1:0] q   [2][$];
  logic [DW-1:0] rlog[2][$];
  bit            hold[2];
  bit            rand_hold;
  int            hold_run;
  int            n_chk;
  int            n_fail;

  typedef struct {
    int          sel;
    int          nw;
    int          nd;
    logic [95:0] d;       // first word in the most significant occupied byte
    int          e_rd, e_err, e_exp, e_pass, e_tmo, e_idle, e_left, e_ren;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic bit ren_of(input int s);
    return (s == 0) ? if_a.r_en : if_b.r_en;
  endfunction

  function automatic bit rrdy_of(input int s);
    return (s == 0) ? if_a.rrdy : if_b.rrdy;
  endfunction

  // Reference: count words differing from the expected value; the expectation always follows the last word + 1.
  function automatic void model(input logic [DW-1:0] w[$], input logic [DW-1:0] sv,
                                output int e, output int x);
    logic [DW-1:0] cur;
    e   = 0;
    cur = sv;
    foreach (w[i]) begin
      if (w[i] != cur) e++;
      cur = w[i] + 8'd1;
    end
    x = int'(cur);
  endfunction

  task automatic drive_fifos();
    if_a.rrdy  = !hold[0] && (q[0].size() != 0);
    if_a.rdata = (q[0].size() != 0) ? q[0][0] : '0;
    if_b.rrdy  = !hold[1] && (q[1].size() != 0);
    if_b.rdata = (q[1].size() != 0) ? q[1][0] : '0;
  endtask

  task automatic tick();
    bit f0, f1;
    f0 = if_a.r_en && if_a.rrdy;
    f1 = if_b.r_en && if_b.rrdy;
    @(posedge clk);
    #1;
    if (f0) rlog[0].push_back(q[0].pop_front());
    if (f1) rlog[1].push_back(q[1].pop_front());
    if (rand_hold && $urandom_range(0, 3) == 0 && hold_run < 5) begin
      hold[0] = 1'b1;
      hold_run++;
    end else begin
      hold[0]  = 1'b0;
      hold_run = 0;
    end
    drive_fifos();
  endtask

  task automatic wait_done(input int s, output int ren_cyc, output int idle);
    int budget;
    ren_cyc = 0;
    idle    = 0;
    budget  = 0;
    while (!o_done[s] && budget < 400) begin
      if (ren_of(s)) ren_cyc++;
      if (o_busy[s] && !rrdy_of(s)) idle++;
      tick();
      budget++;
    end
  endtask

  task automatic run(input int s, input int n, output int ren_cyc, output int idle);
    rlog[s].delete();
    nw[s]    = CW'(n);
    start[s] = 1'b1;
    tick();
    start[s] = 1'b0;
    wait_done(s, ren_cyc, idle);
  endtask

  task automatic load(input int s, input vec_t v);
    q[s].delete();
    for (int i = 0; i < v.nd; i++) q[s].push_back(v.d[8*(v.nd-1-i) +: 8]);
    drive_fifos();
  endtask

  initial begin
    int ren_cyc, idle, e, x, n, nd;
    n_chk     = 0;
    n_fail    = 0;
    rand_hold = 1'b0;
    hold_run  = 0;
    hold[0]   = 1'b0;
    hold[1]   = 1'b0;
    start[0]  = 1'b0;
    start[1]  = 1'b0;
    nw[0]     = '0;
    nw[1]     = '0;
    rst_n     = 1'b0;
    drive_fifos();

    vecs[0] = '{sel:0, nw:10, nd:12, d:96'({8'd1,8'd2,8'd3,8'd4,8'd5,8'd6,8'd7,8'd8,8'd9,8'd10,8'd11,8'd12}),
                e_rd:10, e_err:0, e_exp:11, e_pass:1, e_tmo:0, e_idle:0, e_left:2, e_ren:10};
    vecs[1] = '{sel:0, nw:5, nd:5, d:96'({8'd1,8'd2,8'd3,8'd5,8'd6}),
                e_rd:5, e_err:1, e_exp:7, e_pass:0, e_tmo:0, e_idle:0, e_left:0, e_ren:5};
    vecs[2] = '{sel:1, nw:10, nd:10, d:96'({8'd250,8'd251,8'd252,8'd253,8'd254,8'd255,8'd0,8'd1,8'd2,8'd3}),
                e_rd:10, e_err:0, e_exp:4, e_pass:1, e_tmo:0, e_idle:0, e_left:0, e_ren:10};
    vecs[3] = '{sel:0, nw:4, nd:2, d:96'({8'd1,8'd2}),
                e_rd:2, e_err:0, e_exp:3, e_pass:0, e_tmo:1, e_idle:16, e_left:0, e_ren:18};
    vecs[4] = '{sel:0, nw:0, nd:1, d:96'({8'd1}),
                e_rd:0, e_err:0, e_exp:1, e_pass:1, e_tmo:0, e_idle:0, e_left:1, e_ren:0};
    vecs[5] = '{sel:0, nw:3, nd:3, d:96'({8'd1,8'd9,8'd10}),
                e_rd:3, e_err:1, e_exp:11, e_pass:0, e_tmo:0, e_idle:0, e_left:0, e_ren:3};
    vecs[6] = '{sel:0, nw:4, nd:4, d:96'({8'd0,8'd0,8'd0,8'd0}),
                e_rd:4, e_err:4, e_exp:1, e_pass:0, e_tmo:0, e_idle:0, e_left:0, e_ren:4};
    vecs[7] = '{sel:1, nw:2, nd:2, d:96'({8'd255,8'd0}),
                e_rd:2, e_err:1, e_exp:1, e_pass:0, e_tmo:0, e_idle:0, e_left:0, e_ren:2};

    // Reset values
    #12;
    check("rst_r_en",    int'(if_a.r_en), 0);
    check("rst_busy",    int'(o_busy[0]), 0);
    check("rst_done",    int'(o_done[0]), 0);
    check("rst_pass",    int'(o_pass[0]), 0);
    check("rst_timeout", int'(o_tmo[0]),  0);
    check("rst_rd_cnt",  int'(o_rd[0]),   0);
    check("rst_err_cnt", int'(o_err[0]),  0);
    check("rst_exp_a",   int'(o_exp[0]),  1);
    check("rst_exp_b",   int'(o_exp[1]),  250);
    #10 rst_n = 1'b1;
    tick();

    // Directed table
    foreach (vecs[k]) begin
      load(vecs[k].sel, vecs[k]);
      run(vecs[k].sel, vecs[k].nw, ren_cyc, idle);
      check($sformatf("v%0d_done", k),    int'(o_done[vecs[k].sel]), 1);
      check($sformatf("v%0d_busy", k),    int'(o_busy[vecs[k].sel]), 0);
      check($sformatf("v%0d_r_en", k),    int'(ren_of(vecs[k].sel)), 0);
      check($sformatf("v%0d_rd_cnt", k),  int'(o_rd[vecs[k].sel]),   vecs[k].e_rd);
      check($sformatf("v%0d_err_cnt", k), int'(o_err[vecs[k].sel]),  vecs[k].e_err);
      check($sformatf("v%0d_exp", k),     int'(o_exp[vecs[k].sel]),  vecs[k].e_exp);
      check($sformatf("v%0d_pass", k),    int'(o_pass[vecs[k].sel]), vecs[k].e_pass);
      check($sformatf("v%0d_timeout", k), int'(o_tmo[vecs[k].sel]),  vecs[k].e_tmo);
      check($sformatf("v%0d_idle", k),    idle,                      vecs[k].e_idle);
      check($sformatf("v%0d_left", k),    q[vecs[k].sel].size(),     vecs[k].e_left);
      check($sformatf("v%0d_ren_cyc", k), ren_cyc,                   vecs[k].e_ren);
      repeat (2) tick();
      check($sformatf("v%0d_done_held", k), int'(o_done[vecs[k].sel]), 1);
      q[vecs[k].sel].delete();
      drive_fifos();
    end

    // Asynchronous reset in the middle of a run
    q[0].delete();
    for (int i = 1; i <= 10; i++) q[0].push_back(DW'(i));
    drive_fifos();
    nw[0]    = CW'(10);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (3) tick();
    check("mid_rd_before", int'(o_rd[0]), 3);
    check("mid_busy_before", int'(o_busy[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_r_en", int'(if_a.r_en), 0);
    check("mid_rst_busy", int'(o_busy[0]), 0);
    check("mid_rst_rd",   int'(o_rd[0]),   0);
    check("mid_rst_exp",  int'(o_exp[0]),  1);
    #1 rst_n = 1'b1;
    q[0].delete();
    for (int i = 1; i <= 3; i++) q[0].push_back(DW'(i));
    drive_fifos();
    run(0, 3, ren_cyc, idle);
    check("post_rst_done", int'(o_done[0]), 1);
    check("post_rst_rd",   int'(o_rd[0]),   3);
    check("post_rst_err",  int'(o_err[0]),  0);
    check("post_rst_pass", int'(o_pass[0]), 1);

    // start while running must be ignored
    q[0].delete();
    for (int i = 1; i <= 6; i++) q[0].push_back(DW'(i));
    drive_fifos();
    nw[0]    = CW'(6);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (2) tick();
    nw[0]    = CW'(2);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("ign_rd_cnt", int'(o_rd[0]),   3);
    check("ign_busy",   int'(o_busy[0]), 1);
    wait_done(0, ren_cyc, idle);
    check("ign_done",   int'(o_done[0]), 1);
    check("ign_rd_end", int'(o_rd[0]),   6);
    check("ign_err",    int'(o_err[0]),  0);
    check("ign_exp",    int'(o_exp[0]),  7);
    check("ign_pass",   int'(o_pass[0]), 1);
    q[0].delete();
    drive_fifos();

    // Random runs with stalls and corrupted words against the reference model
    rand_hold = 1'b1;
    for (int t = 0; t < 40; t++) begin
      n  = $urandom_range(1, 12);
      nd = n + $urandom_range(0, 2);
      q[0].delete();
      for (int i = 0; i < nd; i++) begin
        if ($urandom_range(0, 5) == 0) q[0].push_back(DW'($urandom));
        else                           q[0].push_back(DW'(i + 1));
      end
      drive_fifos();
      run(0, n, ren_cyc, idle);
      model(rlog[0], 8'd1, e, x);
      check($sformatf("r%0d_done", t),    int'(o_done[0]), 1);
      check($sformatf("r%0d_nread", t),   rlog[0].size(),  n);
      check($sformatf("r%0d_rd_cnt", t),  int'(o_rd[0]),   n);
      check($sformatf("r%0d_err_cnt", t), int'(o_err[0]),  e);
      check($sformatf("r%0d_exp", t),     int'(o_exp[0]),  x);
      check($sformatf("r%0d_pass", t),    int'(o_pass[0]), (e == 0) ? 1 : 0);
      check($sformatf("r%0d_timeout", t), int'(o_tmo[0]),  0);
    end
    rand_hold = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
